// File: rtl/musicbox_mode_controller.sv
// Music box mode controller: button edge detection, IDLE/SONG0/SONG1/RECORD/PLAYBACK
// mode FSM, 1 ms timebase with per-mode elapsed counter, recording length capture
// and a registered lowest-key priority encoder for the tone generator.
// Optional build macro KEY_LOCKOUT_EN: when defined, key_valid is suppressed in
// SONG0, SONG1 and PLAYBACK so live keys never mix with automatic playback.
module musicbox_mode_controller #(
   parameter int unsigned CLOCKS_PER_MS = 50000,
   parameter int unsigned RECORD_MAX_MS = 10000,
   parameter int unsigned MS_WIDTH      = 14
) (
   input  logic                clock_50Mhz,
   input  logic                reset,
   input  logic [5:0]          musicKeys_s,
   input  logic                playSong0_s,
   input  logic                playSong1_s,
   input  logic                makeRecording_s,
   input  logic                playRecording_s,
   input  logic                song_done,
   output logic [2:0]          mode,
   output logic                song_start,
   output logic                record_enable,
   output logic                playback_enable,
   output logic [MS_WIDTH-1:0] elapsed_ms,
   output logic [MS_WIDTH-1:0] recorded_length_ms,
   output logic [2:0]          key_index,
   output logic                key_valid
);

   localparam int unsigned PRE_W = (CLOCKS_PER_MS > 1) ? $clog2(CLOCKS_PER_MS) : 1;

   typedef enum logic [2:0] {
      MODE_IDLE     = 3'd0,
      MODE_SONG0    = 3'd1,
      MODE_SONG1    = 3'd2,
      MODE_RECORD   = 3'd3,
      MODE_PLAYBACK = 3'd4
   } mode_e;

   // Button bit order: 0 PlaySong0, 1 PlaySong1, 2 MakeRecording, 3 PlayRecording
   logic [3:0]          btn_s;
   logic [3:0]          btn_prev_q;
   logic [3:0]          rise;

   mode_e               mode_q, mode_d;
   logic [MS_WIDTH-1:0] rec_len_q, rec_len_d;
   logic [MS_WIDTH-1:0] elapsed_q;
   logic [PRE_W-1:0]    presc_q;
   logic                song_start_q;
   logic                wrap;
   logic                mode_change;
   logic [2:0]          key_low;
   logic [2:0]          key_index_q;
   logic                key_valid_q;

   assign btn_s       = {playRecording_s, makeRecording_s, playSong1_s, playSong0_s};
   assign rise        = btn_s & ~btn_prev_q;
   assign wrap        = (presc_q == PRE_W'(CLOCKS_PER_MS - 1));
   assign mode_change = (mode_d != mode_q);

   // Previous-value registers reset high so a button held through reset never fires
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) btn_prev_q <= 4'b1111;
      else       btn_prev_q <= btn_s;
   end

   // Next mode and captured recording length
   always_comb begin
      mode_d    = mode_q;
      rec_len_d = rec_len_q;
      case (mode_q)
         MODE_IDLE: begin
            if (rise[0])                                  mode_d = MODE_SONG0;
            else if (rise[1])                             mode_d = MODE_SONG1;
            else if (rise[2])                             mode_d = MODE_RECORD;
            else if (rise[3] && (rec_len_q != '0))        mode_d = MODE_PLAYBACK;
         end
         MODE_SONG0: if (song_done || rise[0]) mode_d = MODE_IDLE;
         MODE_SONG1: if (song_done || rise[1]) mode_d = MODE_IDLE;
         MODE_RECORD: begin
            if (rise[2]) begin
               mode_d    = MODE_IDLE;
               rec_len_d = elapsed_q;
            end else if (elapsed_q >= MS_WIDTH'(RECORD_MAX_MS)) begin
               mode_d    = MODE_IDLE;
               rec_len_d = MS_WIDTH'(RECORD_MAX_MS);
            end
         end
         MODE_PLAYBACK: if ((elapsed_q == rec_len_q) || rise[3]) mode_d = MODE_IDLE;
         default: mode_d = MODE_IDLE;
      endcase
   end

   // Mode register, song-start pulse and timebase (cleared on every mode entry)
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         mode_q       <= MODE_IDLE;
         rec_len_q    <= '0;
         song_start_q <= 1'b0;
         presc_q      <= '0;
         elapsed_q    <= '0;
      end else begin
         mode_q       <= mode_d;
         rec_len_q    <= rec_len_d;
         song_start_q <= mode_change && ((mode_d == MODE_SONG0) || (mode_d == MODE_SONG1));
         if (mode_change) begin
            presc_q   <= '0;
            elapsed_q <= '0;
         end else if (wrap) begin
            presc_q <= '0;
            if (elapsed_q != {MS_WIDTH{1'b1}}) elapsed_q <= elapsed_q + MS_WIDTH'(1);
         end else begin
            presc_q <= presc_q + PRE_W'(1);
         end
      end
   end

   // Lowest pressed key wins
   always_comb begin
      key_low = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (musicKeys_s[i]) key_low = 3'(i);
      end
   end

   // Registered key selection; index holds when no key is pressed
   always_ff @(posedge clock_50Mhz or posedge reset) begin
      if (reset) begin
         key_index_q <= 3'd0;
         key_valid_q <= 1'b0;
      end else if (musicKeys_s != 6'd0) begin
         key_index_q <= key_low;
`ifdef KEY_LOCKOUT_EN
         key_valid_q <= !((mode_q == MODE_SONG0) || (mode_q == MODE_SONG1) ||
                          (mode_q == MODE_PLAYBACK));
`else
         key_valid_q <= 1'b1;
`endif
      end else begin
         key_valid_q <= 1'b0;
      end
   end

   assign mode               = mode_q;
   assign song_start         = song_start_q;
   assign record_enable      = (mode_q == MODE_RECORD);
   assign playback_enable    = (mode_q == MODE_PLAYBACK);
   assign elapsed_ms         = elapsed_q;
   assign recorded_length_ms = rec_len_q;
   assign key_index          = key_index_q;
   assign key_valid          = key_valid_q;

endmodule

// File: doc/musicbox_mode_controller.md
Name: musicbox_mode_controller

Overview:
Downstream consumer of the UI_TriggerSmoother outputs. Edge-detects the smoothed control buttons and runs the music box mode FSM: idle, song 0, song 1, record, playback. Maintains a 1 ms timebase, records the length of a recording, and forwards the live music-key selection to the tone generator. Sits between the input smoothing stage and the song player, recorder and tone blocks.

Parameters:
CLOCKS_PER_MS, 50000, clock_50Mhz cycles per 1 ms tick
RECORD_MAX_MS, 10000, maximum recording length in ms
MS_WIDTH, 14, width of the ms counters; must hold RECORD_MAX_MS

Ports:
clock_50Mhz  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
musicKeys_s  input  6  smoothed music keys, active high
playSong0_s  input  1  smoothed PlaySong0 button, active high
playSong1_s  input  1  smoothed PlaySong1 button, active high
makeRecording_s  input  1  smoothed MakeRecording button, active high
playRecording_s  input  1  smoothed PlayRecording button, active high
song_done  input  1  one-cycle pulse from the song player at the end of a song
mode  output  3  0 IDLE, 1 SONG0, 2 SONG1, 3 RECORD, 4 PLAYBACK
song_start  output  1  one-cycle pulse on entry to SONG0 or SONG1
record_enable  output  1  high while in RECORD
playback_enable  output  1  high while in PLAYBACK
elapsed_ms  output  MS_WIDTH  ms elapsed in the current mode
recorded_length_ms  output  MS_WIDTH  length of the last completed recording
key_index  output  3  index of the lowest-numbered pressed key (0-5)
key_valid  output  1  at least one key is pressed and keys are enabled

Behaviour:
- Reset (async, active-high) values:
  - mode=IDLE; song_start, record_enable, playback_enable, key_valid = 0.
  - elapsed_ms, recorded_length_ms, key_index = 0; prescaler = 0.
  - All edge-detect previous-value registers reset to 1, so a button held through reset does not trigger.
- Edge detect: rise = input & ~prev; prev is registered every cycle.
  - A rise sampled at cycle N produces the new mode at N+1.
  - song_start is high at N+1 only.
- Simultaneous rises in IDLE use this priority: PlaySong0 > PlaySong1 > MakeRecording > PlayRecording. Lower-priority rises are dropped.
- IDLE transitions:
  - playSong0 rise -> SONG0.
  - playSong1 rise -> SONG1.
  - makeRecording rise -> RECORD.
  - playRecording rise -> PLAYBACK if recorded_length_ms != 0; otherwise stay in IDLE.
- SONG0/SONG1: song_done -> IDLE. A rise of the same button aborts -> IDLE. All other buttons are ignored.
- RECORD:
  - makeRecording rise -> IDLE and recorded_length_ms <= elapsed_ms.
  - elapsed_ms reaching RECORD_MAX_MS -> IDLE and recorded_length_ms <= RECORD_MAX_MS.
  - A recording stopped at elapsed_ms=0 stores 0, which invalidates playback.
- PLAYBACK:
  - elapsed_ms == recorded_length_ms -> IDLE.
  - playRecording rise aborts -> IDLE.
  - makeRecording is ignored.
- Timebase:
  - On every mode entry (including return to IDLE), the prescaler and elapsed_ms clear to 0 on the same cycle.
  - The prescaler counts 0..CLOCKS_PER_MS-1 and wraps.
  - The wrap cycle increments elapsed_ms, which saturates at 2^MS_WIDTH-1.
- song_done is ignored outside SONG0/SONG1. If song_done and an abort rise occur together, the result is IDLE.
- Keys: a registered priority encoder selects the lowest set bit of musicKeys_s, 1-cycle latency. With no key pressed: key_valid=0 and key_index holds its last value.
- record_enable and playback_enable are decoded from registered mode (no extra latency).

Optional Feature:
KEY_LOCKOUT_EN:
- Defined: key_valid is forced 0 in SONG0, SONG1 and PLAYBACK, so live keys cannot mix with automatic playback. Keys stay active in IDLE and RECORD.
- Undefined: key_valid follows the keys in every mode.

Test Plan:
Use CLOCKS_PER_MS=10 and RECORD_MAX_MS=5 in simulation.
- Reset with playSong0_s held high, then release reset -> mode stays 0 and song_start never pulses until the button falls and rises again.
- playSong1_s and makeRecording_s rise on the same cycle in IDLE -> next cycle mode=2, song_start=1 for exactly 1 cycle; song_done pulse 30 cycles later -> mode=0.
- makeRecording rise, then a second rise after 35 cycles -> recorded_length_ms=3 and mode=0; then playRecording rise -> mode=4, playback_enable=1, mode returns to 0 once elapsed_ms reaches 3 (about 30 cycles).
- makeRecording rise with no stop -> mode=0 after 50 cycles, recorded_length_ms=5; a playRecording rise after a recording stopped at 0 ms -> mode stays 0.
- musicKeys_s=6'b101000 -> key_index=3, key_valid=1 one cycle later; keys=0 -> key_valid=0 with key_index held at 3.
- KEY_LOCKOUT_EN defined, mode=SONG0, musicKeys_s=6'b000001 -> key_valid=0. Undefined -> key_valid=1, key_index=0.
- Assert reset mid-RECORD at elapsed_ms=2 -> all outputs go to reset values immediately, recorded_length_ms=0.
